// File: rtl/trap_csr_sequencer_if.sv
// rtl/trap_csr_sequencer_if.sv - CSR file read/write port shared by the sequencer
interface trap_csr_sequencer_if #(
    parameter int XLEN = 32
);
    logic            csr_write_enable;
    logic [11:0]     csr_write_address;
    logic [11:0]     csr_read_address;
    logic [XLEN-1:0] csr_write_data;
    logic [XLEN-1:0] csr_read_out;
    logic            csr_ready;

    modport master (
        output csr_write_enable,
        output csr_write_address,
        output csr_read_address,
        output csr_write_data,
        input  csr_read_out,
        input  csr_ready
    );

    modport slave (
        input  csr_write_enable,
        input  csr_write_address,
        input  csr_read_address,
        input  csr_write_data,
        output csr_read_out,
        output csr_ready
    );
endinterface

// File: rtl/trap_csr_sequencer.sv
// rtl/trap_csr_sequencer.sv - shares the CSR port between pipeline CSR ops and trap/mret sequencing
module trap_csr_sequencer #(
    parameter int          XLEN        = 32,
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_enable,
    input  logic                 trap_request,
    input  logic [XLEN-1:0]      trap_pc,
    input  logic [XLEN-1:0]      trap_cause,
    input  logic                 mret_request,
    input  logic                 inst_csr_write_enable,
    input  logic [11:0]          inst_csr_address,
    input  logic [XLEN-1:0]      inst_csr_write_data,
    output logic                 inst_csr_ready,
    output logic [XLEN-1:0]      inst_csr_read_data,
    trap_csr_sequencer_if.master csr_if,
    output logic                 trap_busy,
    output logic                 pc_redirect,
    output logic [XLEN-1:0]      redirect_pc
);
    typedef enum logic [2:0] {
        IDLE, WR_MEPC, GAP, WR_MCAUSE, RD_ADDR, RD_WAIT, REDIRECT
    } state_e;

    typedef enum logic {
        KIND_TRAP, KIND_MRET
    } kind_e;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [XLEN-1:0] pc_l_q, pc_l_d;
    logic [XLEN-1:0] cause_l_q, cause_l_d;
    logic [XLEN-1:0] target_l_q, target_l_d;

    logic            we_c;
    logic [11:0]     waddr_c;
    logic [11:0]     raddr_c;
    logic [XLEN-1:0] wdata_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            kind_q     <= KIND_TRAP;
            pc_l_q     <= '0;
            cause_l_q  <= '0;
            target_l_q <= '0;
        end else if (clk_enable) begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            pc_l_q     <= pc_l_d;
            cause_l_q  <= cause_l_d;
            target_l_q <= target_l_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        kind_d             = kind_q;
        pc_l_d             = pc_l_q;
        cause_l_d          = cause_l_q;
        target_l_d         = target_l_q;
        we_c               = 1'b0;
        waddr_c            = '0;
        raddr_c            = '0;
        wdata_c            = '0;
        inst_csr_ready     = 1'b0;
        inst_csr_read_data = '0;

        case (state_q)
            IDLE: begin
                we_c               = inst_csr_write_enable;
                waddr_c            = inst_csr_address;
                raddr_c            = inst_csr_address;
                wdata_c            = inst_csr_write_data;
                inst_csr_ready     = csr_if.csr_ready;
                inst_csr_read_data = csr_if.csr_read_out;
                // Dropping enable on acceptance guarantees a fresh edge for the mepc write.
                if (trap_request) begin
                    we_c      = 1'b0;
                    pc_l_d    = trap_pc;
                    cause_l_d = trap_cause;
                    kind_d    = KIND_TRAP;
                    state_d   = WR_MEPC;
                end else if (mret_request) begin
                    we_c    = 1'b0;
                    kind_d  = KIND_MRET;
                    state_d = RD_ADDR;
                end
            end
            WR_MEPC: begin
                we_c    = 1'b1;
                waddr_c = MEPC_ADDR;
                wdata_c = pc_l_q;
                state_d = GAP;
            end
            GAP: begin
                state_d = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                we_c    = 1'b1;
                waddr_c = MCAUSE_ADDR;
                wdata_c = cause_l_q;
                state_d = RD_ADDR;
            end
            RD_ADDR: begin
                raddr_c = (kind_q == KIND_TRAP) ? MTVEC_ADDR : MEPC_ADDR;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                raddr_c = (kind_q == KIND_TRAP) ? MTVEC_ADDR : MEPC_ADDR;
                if (csr_if.csr_ready) begin
                    target_l_d = csr_if.csr_read_out & ALIGN_MASK;
                    state_d    = REDIRECT;
                end
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            we_c = 1'b0;
        end
    end

    assign csr_if.csr_write_enable  = we_c;
    assign csr_if.csr_write_address = waddr_c;
    assign csr_if.csr_read_address  = raddr_c;
    assign csr_if.csr_write_data    = wdata_c;

    assign trap_busy   = (state_q != IDLE);
    assign pc_redirect = (state_q == REDIRECT);
    assign redirect_pc = target_l_q;
endmodule
